// File: rtl/imageproc_core.sv
// Command-driven frame-store processor: accepts opcodes, edits a raster frame buffer
// and scans it out as a pixel stream. Optional INVERT op enabled by IMAGEPROC_INVERT_EN.
module imageproc_core #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cmd,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ack,
    output logic       busy,
    output logic       refresh,
    output logic       error,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    output logic       pix_last
);

    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam int AW   = XW + YW;
    localparam int CW   = AW + 1;
    localparam int NPIX = IMG_W * IMG_H;

    localparam logic [CW-1:0] C_LAST = CW'(NPIX - 1);
    localparam logic [CW-1:0] C_END  = CW'(NPIX);
    localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 1);

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_SET_X   = 4'h1;
    localparam logic [3:0] OP_SET_Y   = 4'h2;
    localparam logic [3:0] OP_WRITE   = 4'h3;
    localparam logic [3:0] OP_FILL    = 4'h4;
    localparam logic [3:0] OP_INVERT  = 4'h5;
    localparam logic [3:0] OP_REFRESH = 4'h6;
    localparam logic [3:0] OP_CLR_ERR = 4'hF;

    typedef enum logic [2:0] {S_IDLE, S_ACK, S_FILL, S_INV, S_SCAN} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_armed;
    logic            r_ack;
    logic            r_error;
    logic            r_pix_valid;
    logic            r_pix_last;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_data;
    logic [7:0]      r_rd_data;
    logic [7:0]      r_mem [NPIX];

    logic            w_accept;
    logic            w_op_illegal;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [AW-1:0]   w_raddr;
    logic [7:0]      w_wdata;

    assign w_accept = (r_state == S_IDLE) && cmd_valid && r_armed;

    always_comb begin
        w_op_illegal = 1'b1;
        case (cmd)
            OP_NOP, OP_SET_X, OP_SET_Y, OP_WRITE,
            OP_FILL, OP_REFRESH, OP_CLR_ERR: w_op_illegal = 1'b0;
`ifdef IMAGEPROC_INVERT_EN
            OP_INVERT:                       w_op_illegal = 1'b0;
`endif
            default:                         w_op_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (cmd)
                        OP_FILL:    w_state_next = S_FILL;
`ifdef IMAGEPROC_INVERT_EN
                        OP_INVERT:  w_state_next = S_INV;
`endif
                        OP_REFRESH: w_state_next = S_SCAN;
                        default:    w_state_next = S_ACK;
                    endcase
                end
            end
            S_ACK:         w_state_next = S_IDLE;
            S_FILL, S_INV: if (r_cnt == C_LAST) w_state_next = S_IDLE;
            // Scan runs one extra count so the last read can drain through the read register.
            S_SCAN:        if (r_cnt == C_END) w_state_next = S_IDLE;
            default:       w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed     <= 1'b1;
            r_ack       <= 1'b0;
            r_error     <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
        end else begin
            r_ack <= w_accept;
            if (w_accept)       r_armed <= 1'b0;
            else if (!cmd_valid) r_armed <= 1'b1;

            if (w_accept) begin
                r_data <= cmd_data;
                case (cmd)
                    OP_SET_X: begin
                        if (9'(cmd_data) < 9'(IMG_W)) r_x <= cmd_data[XW-1:0];
                        else                         r_error <= 1'b1;
                    end
                    OP_SET_Y: begin
                        if (9'(cmd_data) < 9'(IMG_H)) r_y <= cmd_data[YW-1:0];
                        else                         r_error <= 1'b1;
                    end
                    OP_WRITE: begin
                        r_x <= r_x + 1'b1;
                        if (r_x == X_MAX) r_y <= r_y + 1'b1;
                    end
                    OP_CLR_ERR: r_error <= 1'b0;
                    default:    if (w_op_illegal) r_error <= 1'b1;
                endcase
            end

            if ((r_state inside {S_FILL, S_INV, S_SCAN}) && (w_state_next != S_IDLE))
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;

            r_pix_valid <= (r_state == S_SCAN) && (r_cnt != C_END);
            r_pix_last  <= (r_state == S_SCAN) && (r_cnt == C_LAST);
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = {r_y, r_x};
        w_wdata = cmd_data;
        if (w_accept && (cmd == OP_WRITE)) w_we = 1'b1;
        if (r_state == S_FILL) begin
            w_we    = 1'b1;
            w_waddr = r_cnt[AW-1:0];
            w_wdata = r_data;
        end
`ifdef IMAGEPROC_INVERT_EN
        // Read of pixel k lands in r_rd_data one cycle ahead of its write-back.
        if (r_state == S_INV) begin
            w_we    = 1'b1;
            w_waddr = r_cnt[AW-1:0];
            w_wdata = ~r_rd_data;
        end
`endif
    end

`ifdef IMAGEPROC_INVERT_EN
    assign w_raddr = (r_state == S_INV) ? r_cnt[AW-1:0] + 1'b1 : r_cnt[AW-1:0];
`else
    assign w_raddr = r_cnt[AW-1:0];
`endif

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
        r_rd_data <= r_mem[w_raddr];
    end

    assign cmd_ack   = r_ack;
    assign busy      = r_state inside {S_FILL, S_INV, S_SCAN};
    assign refresh   = (r_state == S_SCAN);
    assign error     = r_error;
    assign pix_valid = r_pix_valid;
    assign pix_last  = r_pix_last;
    assign pix_data  = r_pix_valid ? r_rd_data : 8'h00;

endmodule

// File: tb/tb_imageproc_core.sv
// Directed bench for imageproc_core: a frame model feeds expected pixels into a
// scoreboard queue that a monitor drains against the scan-out stream.
module tb_imageproc_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cmd = 4'h0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ack, busy, refresh, error, pix_valid, pix_last;
    logic [7:0] pix_data;

    always #5 clk = ~clk;

    imageproc_core #(.IMG_W(16), .IMG_H(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ack(cmd_ack), .busy(busy), .refresh(refresh), .error(error),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_last(pix_last)
    );

    typedef struct { logic [7:0] d; logic last; } pix_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    pix_t       exp_q[$];
    pix_t       mon_e;
    logic [7:0] model_mem [256];
    int         mx = 0;
    int         my = 0;
    logic       model_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && pix_valid) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_pixel observed=%0h expected=none", pix_data);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("pixel", 32'({pix_last, pix_data}), 32'({mon_e.last, mon_e.d}));
            end
        end
    end

    task automatic model_cmd(input logic [3:0] op, input logic [7:0] d);
        case (op)
            4'h0, 4'h6: ;
            4'h1: if (d < 16) mx = int'(d); else model_err = 1'b1;
            4'h2: if (d < 16) my = int'(d); else model_err = 1'b1;
            4'h3: begin
                model_mem[my * 16 + mx] = d;
                mx++;
                if (mx == 16) begin mx = 0; my = (my + 1) % 16; end
            end
            4'h4: foreach (model_mem[i]) model_mem[i] = d;
`ifdef IMAGEPROC_INVERT_EN
            4'h5: foreach (model_mem[i]) model_mem[i] = ~model_mem[i];
`endif
            4'hF: model_err = 1'b0;
            default: model_err = 1'b1;
        endcase
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] d);
        int t;
        @(negedge clk);
        cmd = op; cmd_data = d; cmd_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!cmd_ack && t < 1000);
        check("ack_seen", 32'(cmd_ack), 32'd1);
        cmd_valid = 1'b0;
        model_cmd(op, d);
        check("error_flag", 32'(error), 32'(model_err));
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 2000) begin @(negedge clk); t++; end
        check("busy_done", 32'(busy), 32'd0);
    endtask

    task automatic push_frame();
        pix_t p;
        for (int i = 0; i < 256; i++) begin
            p.d = model_mem[i];
            p.last = (i == 255);
            exp_q.push_back(p);
        end
    endtask

    task automatic do_refresh();
        int t = 0;
        push_frame();
        send(4'h6, 8'h00);
        check("refresh_high", 32'({busy, refresh}), 32'b11);
        while (exp_q.size() != 0 && t < 1000) begin @(negedge clk); t++; end
        check("scan_drained", 32'(exp_q.size()), 32'd0);
        wait_idle();
        check("refresh_low", 32'(refresh), 32'd0);
    endtask

    initial begin
        int t, bc, ab;

        // 1: reset, then single ack for a held NOP
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("in_reset", 32'({cmd_ack, busy, refresh, error, pix_valid, pix_last, pix_data}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset", 32'({cmd_ack, busy, refresh, error, pix_valid, pix_last, pix_data}), 32'd0);
        cmd = 4'h0; cmd_data = 8'h00; cmd_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!cmd_ack && t < 100);
        check("nop_ack", 32'(cmd_ack), 32'd1);
        ab = 0;
        repeat (5) begin @(negedge clk); if (cmd_ack) ab++; end
        check("no_double_ack", 32'(ab), 32'd0);
        cmd_valid = 1'b0;

        // 2: fill, busy length, no ack while busy, then full scan
        send(4'h4, 8'h5A);
        bc = 1;
        @(negedge clk);
        cmd = 4'h0; cmd_data = 8'h00; cmd_valid = 1'b1;
        ab = 0;
        while (busy && bc < 1000) begin
            bc++;
            if (cmd_ack) ab++;
            @(negedge clk);
        end
        check("fill_busy_len", 32'(bc), 32'd256);
        check("ack_while_busy", 32'(ab), 32'd0);
        t = 0;
        while (!cmd_ack && t < 100) begin @(negedge clk); t++; end
        check("ack_after_busy", 32'(cmd_ack), 32'd1);
        cmd_valid = 1'b0;
        do_refresh();

        // 3: cursor wrap at frame end
        send(4'h1, 8'd15);
        send(4'h2, 8'd15);
        send(4'h3, 8'h11);
        send(4'h3, 8'h22);
        do_refresh();

        // 4: out-of-range X sets error and leaves cursor; illegal op; clear
        send(4'h1, 8'd16);
        send(4'h3, 8'h33);
        send(4'h9, 8'h00);
        send(4'hF, 8'h00);
        do_refresh();

        // 5: invert after fill
        send(4'h4, 8'h0F);
        wait_idle();
        send(4'h5, 8'h00);
`ifdef IMAGEPROC_INVERT_EN
        check("invert_busy", 32'(busy), 32'd1);
`else
        check("invert_busy", 32'(busy), 32'd0);
`endif
        wait_idle();
        do_refresh();
        send(4'hF, 8'h00);

        // 6: reset in the middle of a scan
        push_frame();
        send(4'h6, 8'h00);
        t = 0;
        while (exp_q.size() > 156 && t < 1000) begin @(negedge clk); t++; end
        check("scan_progress", 32'(exp_q.size()), 32'd156);
        #2 rst_n = 1'b0;
        #1 check("reset_abort", 32'({busy, refresh, pix_valid, pix_last}), 32'd0);
        exp_q.delete();
        mx = 0; my = 0; model_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(4'h3, 8'h77);
        do_refresh();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
